// File: rtl/atm_account_arbiter.sv
// ---------------------------------------------------------------------------
// atm_account_arbiter
//
// Purpose: arbitrates two ATM terminal front-ends (A and B) onto one shared
// account balance register. Requests are granted round-robin, one transaction
// executes at a time (withdraw / deposit / balance query), and each completes
// with a one-cycle ack plus a registered status and post-transaction balance.
//
// Optional feature: define ATM_DAILY_LIMIT_EN to add a per-terminal
// cumulative withdraw limit (DAILY_LIMIT) with a synchronous clear
// (limit_clr). Without the macro no counters exist and limit_clr is ignored.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   req_a/req_b    level requests, held until the matching ack is seen
//   op_a/op_b      00 withdraw, 01 deposit, 10 query, 11 illegal
//   amt_a/amt_b    transaction amount
//   limit_clr      synchronous clear of both withdraw-limit counters
//   ack_a/ack_b    one-cycle completion pulse
//   status         000 OK, 001 funds, 010 overflow, 011 illegal, 100 limit
//   result         balance after the transaction (valid with ack)
//   balance        live balance register
//   busy           high while a transaction is in EXEC or WAIT
//   grant          terminal being served (0 = A, 1 = B)
// ---------------------------------------------------------------------------
module atm_account_arbiter #(
    parameter int               BAL_W       = 8,
    parameter int               AMT_W       = 6,
    parameter logic [BAL_W-1:0] INIT_BAL    = 8'd50,
    parameter logic [BAL_W-1:0] DAILY_LIMIT = 8'd100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [1:0]       op_a,
    input  logic [1:0]       op_b,
    input  logic [AMT_W-1:0] amt_a,
    input  logic [AMT_W-1:0] amt_b,
    input  logic             limit_clr,
    output logic             ack_a,
    output logic             ack_b,
    output logic [2:0]       status,
    output logic [BAL_W-1:0] result,
    output logic [BAL_W-1:0] balance,
    output logic             busy,
    output logic             grant
);

    localparam logic [2:0] ST_OK      = 3'b000;
    localparam logic [2:0] ST_FUNDS   = 3'b001;
    localparam logic [2:0] ST_OVF     = 3'b010;
    localparam logic [2:0] ST_ILLEGAL = 3'b011;

    typedef enum logic [1:0] {IDLE, EXEC, WAIT} state_t;

    state_t             state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_q, last_d;
    logic [1:0]         op_q, op_d;
    logic [AMT_W-1:0]   amt_q, amt_d;
    logic [BAL_W-1:0]   balance_q, balance_d;
    logic [BAL_W-1:0]   result_q, result_d;
    logic [2:0]         status_q, status_d;
    logic               ack_a_q, ack_a_d;
    logic               ack_b_q, ack_b_d;
    logic               busy_q, busy_d;

    logic               sel_b;
    logic [BAL_W-1:0]   amt_ext;
    logic [BAL_W:0]     dep_sum;

`ifdef ATM_DAILY_LIMIT_EN
    localparam logic [2:0] ST_LIMIT = 3'b100;
    localparam int         CNT_W    = 9;
    localparam int         LIM_W    = CNT_W + 1;

    logic [CNT_W-1:0]   cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0]   cnt_b_q, cnt_b_d;
    logic [LIM_W-1:0]   lim_sum;
    logic [CNT_W-1:0]   lim_next;
    logic               limit_hit;
`else
    logic               unused_limit_clr;
    assign unused_limit_clr = limit_clr;
`endif

    // Next-state and datapath logic. Only the latched operands are used in
    // EXEC, so operand changes after the grant have no effect.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        op_d      = op_q;
        amt_d     = amt_q;
        balance_d = balance_q;
        result_d  = result_q;
        status_d  = status_q;
        ack_a_d   = 1'b0;
        ack_b_d   = 1'b0;
        busy_d    = busy_q;
        sel_b     = 1'b0;
        amt_ext   = {{(BAL_W-AMT_W){1'b0}}, amt_q};
        dep_sum   = {1'b0, balance_q} + {1'b0, amt_ext};
`ifdef ATM_DAILY_LIMIT_EN
        cnt_a_d   = cnt_a_q;
        cnt_b_d   = cnt_b_q;
        lim_sum   = {1'b0, (grant_q ? cnt_b_q : cnt_a_q)} + LIM_W'(amt_q);
        limit_hit = lim_sum > LIM_W'(DAILY_LIMIT);
        lim_next  = lim_sum[CNT_W] ? {CNT_W{1'b1}} : lim_sum[CNT_W-1:0];
`endif

        case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    // On a tie the terminal not served last wins.
                    sel_b   = (req_a && req_b) ? ~last_q : req_b;
                    grant_d = sel_b;
                    op_d    = sel_b ? op_b : op_a;
                    amt_d   = sel_b ? amt_b : amt_a;
                    busy_d  = 1'b1;
                    state_d = EXEC;
                end
            end

            EXEC: begin
                status_d = ST_OK;
                case (op_q)
                    2'b00: begin
`ifdef ATM_DAILY_LIMIT_EN
                        if (limit_hit) begin
                            status_d = ST_LIMIT;
                        end else if (amt_ext > balance_q) begin
                            status_d = ST_FUNDS;
                        end else begin
                            balance_d = balance_q - amt_ext;
                            if (grant_q) cnt_b_d = lim_next;
                            else         cnt_a_d = lim_next;
                        end
`else
                        if (amt_ext > balance_q) status_d  = ST_FUNDS;
                        else                     balance_d = balance_q - amt_ext;
`endif
                    end
                    2'b01: begin
                        if (dep_sum[BAL_W]) status_d  = ST_OVF;
                        else                balance_d = dep_sum[BAL_W-1:0];
                    end
                    2'b10:   status_d = ST_OK;
                    default: status_d = ST_ILLEGAL;
                endcase
                result_d = balance_d;
                ack_a_d  = ~grant_q;
                ack_b_d  = grant_q;
                state_d  = WAIT;
            end

            WAIT: begin
                if (!(grant_q ? req_b : req_a)) begin
                    last_d  = grant_q;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

`ifdef ATM_DAILY_LIMIT_EN
        // The clear overrides any counter update in the same cycle.
        if (limit_clr) begin
            cnt_a_d = '0;
            cnt_b_d = '0;
        end
`endif
    end

    // All state and outputs are registered; reset discards any in-flight
    // transaction without acknowledging it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            op_q      <= 2'b00;
            amt_q     <= '0;
            balance_q <= INIT_BAL;
            result_q  <= '0;
            status_q  <= ST_OK;
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            busy_q    <= 1'b0;
`ifdef ATM_DAILY_LIMIT_EN
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            op_q      <= op_d;
            amt_q     <= amt_d;
            balance_q <= balance_d;
            result_q  <= result_d;
            status_q  <= status_d;
            ack_a_q   <= ack_a_d;
            ack_b_q   <= ack_b_d;
            busy_q    <= busy_d;
`ifdef ATM_DAILY_LIMIT_EN
            cnt_a_q   <= cnt_a_d;
            cnt_b_q   <= cnt_b_d;
`endif
        end
    end

    assign ack_a   = ack_a_q;
    assign ack_b   = ack_b_q;
    assign status  = status_q;
    assign result  = result_q;
    assign balance = balance_q;
    assign busy    = busy_q;
    assign grant   = grant_q;

endmodule

// File: tb/tb_atm_account_arbiter.sv
// ---------------------------------------------------------------------------
// tb_atm_account_arbiter
//
// Directed testbench for atm_account_arbiter. Stimulus code pushes the
// hand-computed response of every transaction into a scoreboard queue; an
// independent monitor pops and compares whenever an ack appears.
// ---------------------------------------------------------------------------
module tb_atm_account_arbiter;

    localparam logic [2:0] ST_OK      = 3'b000;
    localparam logic [2:0] ST_FUNDS   = 3'b001;
    localparam logic [2:0] ST_OVF     = 3'b010;
    localparam logic [2:0] ST_ILLEGAL = 3'b011;
    localparam logic [2:0] ST_LIMIT   = 3'b100;

    localparam logic [1:0] OP_WD  = 2'b00;
    localparam logic [1:0] OP_DEP = 2'b01;
    localparam logic [1:0] OP_QRY = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_a = 1'b0, req_b = 1'b0;
    logic [1:0] op_a = 2'b00, op_b = 2'b00;
    logic [5:0] amt_a = '0, amt_b = '0;
    logic       limit_clr = 1'b0;
    logic       ack_a, ack_b, busy, grant;
    logic [2:0] status;
    logic [7:0] result, balance;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         term;
        logic [2:0] st;
        logic [7:0] res;
    } exp_t;

    exp_t sb[$];

    atm_account_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .req_b     (req_b),
        .op_a      (op_a),
        .op_b      (op_b),
        .amt_a     (amt_a),
        .amt_b     (amt_b),
        .limit_clr (limit_clr),
        .ack_a     (ack_a),
        .ack_b     (ack_b),
        .status    (status),
        .result    (result),
        .balance   (balance),
        .busy      (busy),
        .grant     (grant)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic expectTxn(input bit term, input logic [2:0] st, input logic [7:0] res);
        exp_t e;
        e.term = term;
        e.st   = st;
        e.res  = res;
        sb.push_back(e);
    endtask

    // Monitor: every ack must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ack_a && ack_b) begin
                checks++;
                errors++;
                $display("[TB] FAIL dual_ack: both acks high");
            end else if (ack_a || ack_b) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_ack: ack_a=%0b ack_b=%0b with empty scoreboard", ack_a, ack_b);
                end else begin
                    e = sb.pop_front();
                    checkOutput("ack_terminal", int'(ack_b), int'(e.term));
                    checkOutput("status", int'(status), int'(e.st));
                    checkOutput("result", int'(result), int'(e.res));
                    checkOutput("balance_at_ack", int'(balance), int'(e.res));
                end
            end
        end
    end

    // Reset the DUT and check every reset value.
    task automatic doReset();
        @(negedge clk);
        rst   = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_balance", int'(balance), 50);
        checkOutput("rst_result", int'(result), 0);
        checkOutput("rst_status", int'(status), 0);
        checkOutput("rst_ack", int'({ack_a, ack_b}), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_grant", int'(grant), 0);
        rst = 1'b1;
    endtask

    // Raise the selected requests on the same edge, drop each on its ack.
    task automatic applyStimulus(input bit ra, input logic [1:0] opa, input logic [5:0] amta,
                                 input bit rb, input logic [1:0] opb, input logic [5:0] amtb,
                                 input bit drop_a_early);
        bit done_a, done_b;
        int cyc;
        @(negedge clk);
        op_a  = opa;
        amt_a = amta;
        op_b  = opb;
        amt_b = amtb;
        req_a = ra;
        req_b = rb;
        done_a = !ra;
        done_b = !rb;
        cyc = 0;
        while (!(done_a && done_b) && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1 && !(ra && rb)) begin
                checkOutput("busy_after_grant", int'(busy), 1);
                checkOutput("grant_value", int'(grant), int'(rb));
                if (drop_a_early) req_a = 1'b0;
            end
            if (ack_a && !done_a) begin
                done_a = 1'b1;
                req_a  = 1'b0;
                if (!rb) checkOutput("latency_a", cyc, 2);
            end
            if (ack_b && !done_b) begin
                done_b = 1'b1;
                req_b  = 1'b0;
                if (!ra) checkOutput("latency_b", cyc, 2);
            end
        end
        if (!(done_a && done_b)) begin
            checks++;
            errors++;
            $display("[TB] FAIL ack_timeout: done_a=%0b done_b=%0b required 1 1", done_a, done_b);
            req_a = 1'b0;
            req_b = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic txnA(input logic [1:0] op, input logic [5:0] amt,
                        input logic [2:0] st, input logic [7:0] res);
        expectTxn(1'b0, st, res);
        applyStimulus(1'b1, op, amt, 1'b0, 2'b00, 6'd0, 1'b0);
    endtask

    task automatic txnB(input logic [1:0] op, input logic [5:0] amt,
                        input logic [2:0] st, input logic [7:0] res);
        expectTxn(1'b1, st, res);
        applyStimulus(1'b0, 2'b00, 6'd0, 1'b1, op, amt, 1'b0);
    endtask

    initial begin
        int wait_cyc;

        // Deposit after reset.
        doReset();
        txnA(OP_DEP, 6'd10, ST_OK, 8'd60);
        checkOutput("balance_after_dep", int'(balance), 60);

        // Insufficient funds, then exact drain.
        doReset();
        txnB(OP_WD, 6'd51, ST_FUNDS, 8'd50);
        txnB(OP_WD, 6'd50, ST_OK, 8'd0);

        // Build balance to 250, then overflow and illegal op.
        doReset();
        txnA(OP_DEP, 6'd63, ST_OK, 8'd113);
        txnA(OP_DEP, 6'd63, ST_OK, 8'd176);
        txnA(OP_DEP, 6'd63, ST_OK, 8'd239);
        txnA(OP_DEP, 6'd11, ST_OK, 8'd250);
        txnA(OP_DEP, 6'd10, ST_OVF, 8'd250);
        txnA(OP_ILL, 6'd5, ST_ILLEGAL, 8'd250);
        checkOutput("balance_after_ovf", int'(balance), 250);

        // Same-edge requests: A wins after reset, B is served next.
        doReset();
        expectTxn(1'b0, ST_OK, 8'd55);
        expectTxn(1'b1, ST_OK, 8'd35);
        applyStimulus(1'b1, OP_DEP, 6'd5, 1'b1, OP_WD, 6'd20, 1'b0);
        // A served alone makes B the tie winner next.
        txnA(OP_QRY, 6'd9, ST_OK, 8'd35);
        expectTxn(1'b1, ST_OK, 8'd42);
        expectTxn(1'b0, ST_OK, 8'd32);
        applyStimulus(1'b1, OP_WD, 6'd10, 1'b1, OP_DEP, 6'd7, 1'b0);

        // Reset while B's deposit is in EXEC: no ack, state restored.
        doReset();
        @(negedge clk);
        op_b  = OP_DEP;
        amt_b = 6'd10;
        req_b = 1'b1;
        @(negedge clk);
        checkOutput("grant_b_before_rst", int'(grant), 1);
        rst   = 1'b0;
        req_b = 1'b0;
        @(negedge clk);
        checkOutput("midrst_ack_b", int'(ack_b), 0);
        checkOutput("midrst_balance", int'(balance), 50);
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_grant", int'(grant), 0);
        rst = 1'b1;
        txnA(OP_QRY, 6'd0, ST_OK, 8'd50);

        // Request dropped during EXEC still completes; zero amount is legal.
        expectTxn(1'b0, ST_OK, 8'd45);
        applyStimulus(1'b1, OP_WD, 6'd5, 1'b0, 2'b00, 6'd0, 1'b1);
        txnA(OP_WD, 6'd0, ST_OK, 8'd45);

`ifdef ATM_DAILY_LIMIT_EN
        // Daily withdraw limit and its clear.
        doReset();
        txnA(OP_DEP, 6'd63, ST_OK, 8'd113);
        txnA(OP_DEP, 6'd63, ST_OK, 8'd176);
        txnA(OP_DEP, 6'd24, ST_OK, 8'd200);
        txnA(OP_WD, 6'd60, ST_OK, 8'd140);
        txnA(OP_WD, 6'd50, ST_LIMIT, 8'd140);
        @(negedge clk);
        limit_clr = 1'b1;
        @(negedge clk);
        limit_clr = 1'b0;
        txnA(OP_WD, 6'd50, ST_OK, 8'd90);
`endif

        // Every expected response must have been consumed.
        wait_cyc = 0;
        while (sb.size() != 0 && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        checkOutput("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
